// File: rtl/vector_result_serializer_if.sv
// Element-wide valid/ready stream that carries one vector element per beat.
interface vector_result_serializer_if #(
  parameter int BITS = 8,
  parameter int N    = 4
) ();
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [BITS-1:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  logic [IW-1:0]   m_index;

  modport master (output m_data, m_valid, m_last, m_index, input m_ready);
  modport slave  (input m_data, m_valid, m_last, m_index, output m_ready);
endinterface

// File: rtl/vector_result_serializer.sv
// Snapshots the ALU result vector on capture and drains it element by element
// onto a valid/ready stream, with a sticky flag for captures that had to be dropped.
module vector_result_serializer #(
  parameter int BITS      = 8,
  parameter int N         = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BITS-1:0]            S [N-1:0],
  input  logic                       capture,
  input  logic                       clear_overrun,
  vector_result_serializer_if.master m,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_CNT = IW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   count_q, count_d;
  logic [BITS-1:0] buf_q [N-1:0];
  logic [BITS-1:0] buf_d [N-1:0];
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;

  logic            streaming;
  logic            at_last;
  logic            fire;
  logic [IW-1:0]   elem;

  always_comb begin
    streaming = (state_q == STREAM);
    at_last   = (count_q == LAST_CNT);
    fire      = streaming && m.m_ready;
    elem      = LSB_FIRST ? count_q : (LAST_CNT - count_q);
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    buf_d     = buf_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    if (clear_overrun) overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          buf_d   = S;
          count_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (fire && at_last) begin
          // A capture landing on the final beat chains the next vector without a bubble.
          done_d  = 1'b1;
          count_d = '0;
          if (capture) buf_d = S;
          else         state_d = IDLE;
        end else begin
          if (fire)    count_d = count_q + IW'(1);
          if (capture) overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      buf_q     <= buf_d;
    end
  end

  // Outputs come straight from registered state, so they hold under backpressure.
  always_comb begin
    m.m_valid = streaming;
    m.m_data  = streaming ? buf_q[elem] : '0;
    m.m_index = streaming ? elem : '0;
    m.m_last  = streaming && at_last;
    busy      = streaming;
    done      = done_q;
    overrun   = overrun_q;
  end
endmodule
